// File: rtl/onehot_pkg.sv
// Shared constants and one-hot helpers for the round-robin mux.
package onehot_pkg;

  localparam int unsigned ONEHOT_MAX_N = 16;
  localparam int unsigned ONEHOT_CNT_W = 16;
  localparam int unsigned ONEHOT_IDX_W = 4;

  typedef logic [ONEHOT_CNT_W-1:0] onehot_cnt_t;

  // True when zero or exactly one bit is set.
  function automatic logic onehot_is_valid(input logic [ONEHOT_MAX_N-1:0] v);
    return (v & (v - ONEHOT_MAX_N'(1))) == '0;
  endfunction

  function automatic logic [ONEHOT_IDX_W-1:0] onehot_to_idx(input logic [ONEHOT_MAX_N-1:0] v);
    logic [ONEHOT_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ONEHOT_MAX_N; i++) begin
      if (v[i]) idx = ONEHOT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_rr_arb.sv
// Round-robin arbiter: rotate requests by prio_ptr, pick lowest set bit, rotate back.
module onehot_rr_arb
  import onehot_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_aL,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_c_o
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0]           prio_ptr_q, prio_ptr_d;
  logic [N-1:0]            rot_c, pri_c, grant_c;
  logic [ONEHOT_IDX_W-1:0] gidx_c;
  int unsigned             nxt_c;

  always_comb begin
    rot_c   = (req_i >> prio_ptr_q) | (req_i << (N - 32'(prio_ptr_q)));
    pri_c   = rot_c & (~rot_c + N'(1));
    grant_c = '0;
    if (en_i) grant_c = (pri_c << prio_ptr_q) | (pri_c >> (N - 32'(prio_ptr_q)));
  end

  assign grant_c_o = grant_c;

  // Pointer moves to the slot just past the winner; a denied channel keeps its turn.
  always_comb begin
    gidx_c     = onehot_to_idx(ONEHOT_MAX_N'(grant_c));
    nxt_c      = 32'(gidx_c) + 32'd1;
    if (nxt_c >= N) nxt_c = 32'd0;
    prio_ptr_d = prio_ptr_q;
    if (advance_i) prio_ptr_d = PW'(nxt_c);
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) prio_ptr_q <= '0;
    else         prio_ptr_q <= prio_ptr_d;
  end

endmodule

// File: rtl/onehot_rr_mux.sv
// N-channel round-robin one-hot mux with a one-entry registered valid/ready output.
// Optional per-channel grant counters enabled by ONEHOT_RR_MUX_STATS_EN.
module onehot_rr_mux
  import onehot_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_aL,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel
`ifdef ONEHOT_RR_MUX_STATS_EN
  ,
  output logic [N*ONEHOT_CNT_W-1:0] grant_cnt
`endif
);

  logic         free_c, en_c, xfer_c;
  logic [N-1:0] grant_c;
  logic [W-1:0] data_c;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [N-1:0] out_sel_q, out_sel_d;

  // Reset gates the grant so nothing is accepted while rst_aL is low.
  assign free_c = ~out_valid_q | out_ready;
  assign en_c   = free_c & rst_aL;
  assign xfer_c = |grant_c;

  onehot_rr_arb #(.N(N)) u_arb (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .req_i     (in_valid),
    .en_i      (en_c),
    .advance_i (xfer_c),
    .grant_c_o (grant_c)
  );

  assign in_ready = grant_c;

  always_comb begin
    data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      data_c = data_c | (in_data[i*W +: W] & {W{grant_c[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = data_c;
      out_sel_d   = grant_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef ONEHOT_RR_MUX_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_cnt
    onehot_cnt_t cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (grant_c[i] && (cnt_q != '1)) cnt_d = cnt_q + ONEHOT_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign grant_cnt[i*ONEHOT_CNT_W +: ONEHOT_CNT_W] = cnt_q;
  end
`endif

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_aL)
    onehot_is_valid(ONEHOT_MAX_N'(in_ready)));
`endif

endmodule

// File: tb/tb_onehot_rr_mux.sv
// Directed self-checking bench for onehot_rr_mux (N=4, W=32).
module tb_onehot_rr_mux;
  import onehot_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_aL;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_sel;
`ifdef ONEHOT_RR_MUX_STATS_EN
  logic [N*ONEHOT_CNT_W-1:0] grant_cnt;
`endif

  int tests;
  int fails;

  onehot_rr_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef ONEHOT_RR_MUX_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    rst_aL    = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_aL = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_aL    = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    tests++; if (out_sel !== 4'b0000) begin fails++; $display("FAIL reset_out_sel: got %b expected 0000", out_sel); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    in_valid = '0;
    rst_aL   = 1'b1;
  endtask

  task automatic test_single_request;
    do_reset();
    in_valid           = 4'b0100;
    in_data[2*W +: W]  = 32'h0000FF00;
    out_ready          = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL single_in_ready: got %b expected 0100", in_ready); end
    @(posedge clk); #1;
    in_valid = '0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 32'h0000FF00) begin fails++; $display("FAIL single_out_data: got %h expected 0000ff00", out_data); end
    tests++; if (out_sel !== 4'b0100) begin fails++; $display("FAIL single_out_sel: got %b expected 0100", out_sel); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'h0000FF00) begin fails++; $display("FAIL single_drain_data_hold: got %h expected 0000ff00", out_data); end
    tests++; if (out_sel !== 4'b0100) begin fails++; $display("FAIL single_drain_sel_hold: got %b expected 0100", out_sel); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_sel [8];
    logic [W-1:0] exp_dat [8];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_dat = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
    do_reset();
    in_data[0*W +: W] = 32'hA0000000;
    in_data[1*W +: W] = 32'hA0000001;
    in_data[2*W +: W] = 32'hA0000002;
    in_data[3*W +: W] = 32'hA0000003;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++; if (in_ready !== exp_sel[k]) begin fails++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, exp_sel[k]); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rr_out_valid[%0d]: got %b expected 1", k, out_valid); end
      tests++; if (out_sel !== exp_sel[k]) begin fails++; $display("FAIL rr_out_sel[%0d]: got %b expected %b", k, out_sel, exp_sel[k]); end
      tests++; if (out_data !== exp_dat[k]) begin fails++; $display("FAIL rr_out_data[%0d]: got %h expected %h", k, out_data, exp_dat[k]); end
    end
    in_valid = '0;
  endtask

  task automatic test_stall;
    do_reset();
    in_valid          = 4'b0001;
    in_data[0*W +: W] = 32'h00000011;
    in_data[1*W +: W] = 32'h00000022;
    out_ready         = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", k, in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, out_valid); end
      tests++; if (out_data !== 32'h00000011) begin fails++; $display("FAIL stall_data[%0d]: got %h expected 00000011", k, out_data); end
      tests++; if (out_sel !== 4'b0001) begin fails++; $display("FAIL stall_sel[%0d]: got %b expected 0001", k, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL stall_resume_ready: got %b expected 0010", in_ready); end
    @(posedge clk); #1;
    in_valid = '0;
    tests++; if (out_sel !== 4'b0010) begin fails++; $display("FAIL stall_resume_sel: got %b expected 0010", out_sel); end
    tests++; if (out_data !== 32'h00000022) begin fails++; $display("FAIL stall_resume_data: got %h expected 00000022", out_data); end
  endtask

  task automatic test_drain_fill;
    in_valid          = 4'b1000;
    in_data[3*W +: W] = 32'hDEADBEEF;
    out_ready         = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL df_pre_valid: got %b expected 1", out_valid); end
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL df_in_ready: got %b expected 1000", in_ready); end
    @(posedge clk); #1;
    in_valid  = '0;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL df_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL df_data: got %h expected deadbeef", out_data); end
    tests++; if (out_sel !== 4'b1000) begin fails++; $display("FAIL df_sel: got %b expected 1000", out_sel); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst_aL = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL ar_data: got %h expected 00000000", out_data); end
    tests++; if (out_sel !== 4'b0000) begin fails++; $display("FAIL ar_sel: got %b expected 0000", out_sel); end
    @(negedge clk);
    rst_aL            = 1'b1;
    in_valid          = 4'b1010;
    in_data[1*W +: W] = 32'h00000101;
    in_data[3*W +: W] = 32'h00000303;
    out_ready         = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL ar_first_ready: got %b expected 0010", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 4'b0010) begin fails++; $display("FAIL ar_first_sel: got %b expected 0010", out_sel); end
    tests++; if (out_data !== 32'h00000101) begin fails++; $display("FAIL ar_first_data: got %h expected 00000101", out_data); end
    #1;
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL ar_second_ready: got %b expected 1000", in_ready); end
    @(posedge clk); #1;
    in_valid = '0;
    tests++; if (out_sel !== 4'b1000) begin fails++; $display("FAIL ar_second_sel: got %b expected 1000", out_sel); end
  endtask

`ifdef ONEHOT_RR_MUX_STATS_EN
  task automatic test_stats;
    do_reset();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (grant_cnt[0 +: 16] !== 16'd5) begin fails++; $display("FAIL stats_cnt0_early: got %0d expected 5", grant_cnt[0 +: 16]); end
    repeat (69995) @(posedge clk);
    #1;
    in_valid = '0;
    tests++; if (grant_cnt[0 +: 16] !== 16'hFFFF) begin fails++; $display("FAIL stats_cnt0_sat: got %h expected ffff", grant_cnt[0 +: 16]); end
    tests++; if (grant_cnt[16 +: 48] !== 48'h0) begin fails++; $display("FAIL stats_others: got %h expected 0", grant_cnt[16 +: 48]); end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    rst_aL    = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_stall();
    test_drain_fill();
    test_async_reset();
`ifdef ONEHOT_RR_MUX_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
